// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF on-the-fly converter: signed-digit encodings
// and the controller state type.
package msdf_pkg;

    localparam logic [1:0] DIGIT_POS  = 2'b10;
    localparam logic [1:0] DIGIT_NEG  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } otf_state_t;

endpackage

// File: rtl/msdf_otf_step.sv
// One on-the-fly conversion step: shifts the Q/QM pair left by one digit.
// Purely combinational; any digit code other than +1/-1 converts as 0.
module msdf_otf_step
    import msdf_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   d,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    localparam logic [W-1:0] ONE = W'(1);

    // Left shifts drop the MSB; the result range always fits in W bits.
    always_comb begin
        q_next  = q << 1;
        qm_next = (qm << 1) | ONE;
        unique case (d)
            DIGIT_POS: begin
                q_next  = (q << 1) | ONE;
                qm_next = q << 1;
            end
            DIGIT_NEG: begin
                q_next  = (qm << 1) | ONE;
                qm_next = qm << 1;
            end
            default: begin
                q_next  = q << 1;
                qm_next = (qm << 1) | ONE;
            end
        endcase
    end

endmodule

// File: rtl/msdf_otf_converter.sv
// MSDF signed-digit stream to two's-complement converter using Q/QM registers.
// Optional invalid-digit (2'b11) flag built only with MSDF_OTF_DIGIT_CHECK_EN.
module msdf_otf_converter
    import msdf_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         io_start,
    input  logic [1:0]   io_d,
    output logic [N:0]   io_q,
    output logic         io_done,
    output logic         io_busy,
    output logic         io_err
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    otf_state_t state, state_next;
    logic [N:0]    q, qm, q_src, qm_src, q_step, qm_step;
    logic [CW-1:0] cnt;
    logic          apply, init, finish;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (io_start) state_next = RUN;
            RUN:  if (!io_start && cnt == CNT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A start in RUN restarts the stream; the partial result is dropped.
    always_comb begin
        init    = io_start;
        apply   = io_start || (state == RUN);
        finish  = (state == RUN) && !io_start && (cnt == CNT_LAST);
        io_busy = (state == RUN);
    end

    assign q_src  = init ? '0 : q;
    assign qm_src = init ? '1 : qm;

    msdf_otf_step #(.W(N + 1)) u_step (
        .q       (q_src),
        .qm      (qm_src),
        .d       (io_d),
        .q_next  (q_step),
        .qm_next (qm_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            qm      <= '1;
            cnt     <= '0;
            io_q    <= '0;
            io_done <= 1'b0;
        end else begin
            io_done <= finish;
            if (apply) begin
                q  <= q_step;
                qm <= qm_step;
                if (init)        cnt <= CW'(1);
                else if (finish) cnt <= '0;
                else             cnt <= cnt + CW'(1);
            end
            if (finish) io_q <= q_step;
        end
    end

`ifdef MSDF_OTF_DIGIT_CHECK_EN
    logic err_acc, err_acc_next;

    assign err_acc_next = (init ? 1'b0 : err_acc) | (io_d == 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_acc <= 1'b0;
            io_err  <= 1'b0;
        end else begin
            if (apply)  err_acc <= err_acc_next;
            if (finish) io_err  <= err_acc_next;
        end
    end
`else
    assign io_err = 1'b0;
`endif

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Directed self-checking bench for msdf_otf_converter (N=8).
module tb_msdf_otf_converter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         io_start = 1'b0;
    logic [1:0]   io_d = 2'b00;
    logic [N:0]   io_q;
    logic         io_done, io_busy, io_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int base_cnt, first_cyc;

    msdf_otf_converter #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_start (io_start),
        .io_d     (io_d),
        .io_q     (io_q),
        .io_done  (io_done),
        .io_busy  (io_busy),
        .io_err   (io_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents digits [0..count-1] of a packed 8-digit stream, start on the first.
    task automatic feed(input logic [15:0] ds, input int count);
        for (int i = 0; i < count; i++) begin
            io_start = (i == 0);
            io_d     = ds[15 - 2*i -: 2];
            tick();
        end
        io_start = 1'b0;
        io_d     = 2'b00;
    endtask

    localparam logic [15:0] S_080  = 16'b10_00_00_00_00_00_00_00;
    localparam logic [15:0] S_NEG  = 16'b01_01_01_01_01_01_01_01;
    localparam logic [15:0] S_02B  = 16'b00_10_01_10_01_10_01_10;
    localparam logic [15:0] S_040  = 16'b10_01_00_00_00_00_00_00;
    localparam logic [15:0] S_BAD  = 16'b10_00_11_00_00_00_00_00;

    initial begin
        // Reset state
        #3;
        chk("rst_q", 32'(io_q), 32'h000);
        chk("rst_done", 32'(io_done), 32'h0);
        chk("rst_busy", 32'(io_busy), 32'h0);
        chk("rst_err", 32'(io_err), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Digits while idle without start are ignored
        io_d = 2'b10;
        tick(); tick();
        io_d = 2'b00;
        chk("idle_ignore_busy", 32'(io_busy), 32'h0);
        chk("idle_ignore_done", 32'(done_cnt), 32'd0);

        // +1,0,... -> 0x080, done 8 cycles after start
        base_cnt = done_cnt;
        io_start = 1'b1; io_d = 2'b10;
        tick();
        first_cyc = cyc;
        io_start = 1'b0; io_d = 2'b00;
        chk("busy_mid", 32'(io_busy), 32'h1);
        for (int i = 0; i < 6; i++) tick();
        chk("no_early_done", 32'(done_cnt), 32'(base_cnt));
        tick();
        chk("p080_done", 32'(io_done), 32'h1);
        chk("p080_q", 32'(io_q), 32'h080);
        chk("p080_busy_low", 32'(io_busy), 32'h0);
        chk("p080_err", 32'(io_err), 32'h0);
        tick();
        chk("p080_latency", 32'(done_cyc - first_cyc), 32'd7);
        chk("p080_pulse_one", 32'(io_done), 32'h0);
        chk("p080_hold", 32'(io_q), 32'h080);

        // All -1 -> -255
        feed(S_NEG, 8);
        chk("neg_done", 32'(io_done), 32'h1);
        chk("neg_q", 32'(io_q), 32'h101);
        tick();

        // Alternating -> 43
        feed(S_02B, 8);
        chk("alt_q", 32'(io_q), 32'h02B);
        tick();

        // +1,-1,0... -> 64
        feed(S_040, 8);
        chk("pm_q", 32'(io_q), 32'h040);
        tick();

        // Back-to-back streams, zero gap
        base_cnt = done_cnt;
        feed(S_080, 8);
        chk("b2b_first_done", 32'(io_done), 32'h1);
        chk("b2b_first_q", 32'(io_q), 32'h080);
        io_start = 1'b1; io_d = 2'b01;
        tick();
        first_cyc = done_cyc;
        chk("b2b_busy_seam", 32'(io_busy), 32'h1);
        chk("b2b_first_held", 32'(io_q), 32'h080);
        io_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        io_d = 2'b00;
        chk("b2b_second_done", 32'(io_done), 32'h1);
        chk("b2b_second_q", 32'(io_q), 32'h101);
        tick();
        chk("b2b_spacing", 32'(done_cyc - first_cyc), 32'd8);
        chk("b2b_pulses", 32'(done_cnt - base_cnt), 32'd2);

        // Alternating result first so the restart result is distinguishable
        feed(S_02B, 8);
        tick();
        base_cnt = done_cnt;
        feed(S_NEG, 3);
        feed(S_080, 8);
        chk("restart_done", 32'(io_done), 32'h1);
        chk("restart_q", 32'(io_q), 32'h080);
        tick();
        chk("restart_one_pulse", 32'(done_cnt - base_cnt), 32'd1);

        // Reset at digit 5
        feed(S_NEG, 8);
        tick();
        base_cnt = done_cnt;
        feed(S_02B, 4);
        io_d = 2'b10;
        #1;
        chk("pre_reset_busy", 32'(io_busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_q", 32'(io_q), 32'h000);
        chk("async_rst_busy", 32'(io_busy), 32'h0);
        chk("async_rst_done", 32'(io_done), 32'h0);
        chk("async_rst_err", 32'(io_err), 32'h0);
        io_d = 2'b00;
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_no_done", 32'(done_cnt - base_cnt), 32'd0);
        feed(S_02B, 8);
        chk("post_rst_done", 32'(io_done), 32'h1);
        chk("post_rst_q", 32'(io_q), 32'h02B);
        tick();

        // Invalid digit converts as 0
        feed(S_BAD, 8);
        chk("bad_q", 32'(io_q), 32'h080);
`ifdef MSDF_OTF_DIGIT_CHECK_EN
        chk("bad_err", 32'(io_err), 32'h1);
        tick();
        chk("bad_err_held", 32'(io_err), 32'h1);
        feed(S_040, 8);
        chk("clean_err", 32'(io_err), 32'h0);
        chk("clean_q", 32'(io_q), 32'h040);
`else
        chk("bad_err_off", 32'(io_err), 32'h0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
